counter_sched: RTL and testbench
================================

Name: counter_sched

Overview:
- Round-robin scheduler that shares one three-bit load/increment counter between two requesters, A and B.
- Serialises each requester's load or increment command onto the counter's ld/inc/data_in inputs, and reports completion.
- Enforces the no-wrap rule in hardware: an increment is refused when the counter already holds MAX_COUNT, so the counter's own assertion never fires.
- Sits between requester logic and the counter instance; it is the only driver of the counter controls.

Parameters:
- WIDTH, 3, counter data width.
- MAX_COUNT, 7, counter value at which an increment is refused; must be <= 2**WIDTH-1.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- req_a  input  1  requester A command request
- op_a  input  1  requester A op: 0=increment, 1=load
- data_a  input  WIDTH  requester A load value
- req_b  input  1  requester B command request
- op_b  input  1  requester B op: 0=increment, 1=load
- data_b  input  WIDTH  requester B load value
- gnt_a  output  1  one-cycle grant to A
- gnt_b  output  1  one-cycle grant to B
- done  output  1  one-cycle completion pulse
- done_id  output  1  requester served: 0=A, 1=B; valid only with done
- err  output  1  with done: increment refused at MAX_COUNT
- busy  output  1  high while state != IDLE
- ctr_ld  output  1  to counter ld
- ctr_inc  output  1  to counter inc
- ctr_data  output  WIDTH  to counter data_in
- ctr_q  input  WIDTH  from counter data_out
- reject_cnt  output  8  saturating count of refused increments

Behaviour:
- One clock; reset is synchronous and active-high.
- All outputs are registered.
- Reset values: state=IDLE, priority pointer=A, reject_cnt=0, and every other output=0.
- FSM states: IDLE -> ISSUE -> DONE -> IDLE. Fixed 3-cycle occupancy per command.
- IDLE, at the edge where req_a|req_b=1:
  - Pick the winner. If both request, the priority pointer wins; otherwise the sole requester wins.
  - Latch the winner's op and data.
  - Next state: ISSUE. The same edge sets gnt_<winner>=1, ctr_data=data (loads only), and ctr_ld=op.
  - ctr_inc = !op && (ctr_q != MAX_COUNT), with ctr_q sampled at this edge.
  - Set the internal flag rej = !op && (ctr_q == MAX_COUNT).
- ISSUE cycle:
  - gnt and ctr_ld/ctr_inc are high for exactly this one cycle; the counter updates at the edge ending it.
  - At that edge: gnt, ctr_ld, ctr_inc and ctr_data go to 0; done=1; done_id=winner; err=rej.
  - Also at that edge: reject_cnt increments if rej and reject_cnt != 255.
  - Also at that edge: the priority pointer moves to the non-winner.
  - Next state: DONE.
- DONE cycle:
  - done is high and ctr_q holds the post-operation value.
  - Next edge: done=0, err=0, state=IDLE.
  - Requests are not sampled in DONE.
- Latency: request sampled at edge E0, gnt the cycle after E0, done the cycle after E1. Back-to-back throughput is one command per 3 cycles.
- Requester rules:
  - Hold req/op/data stable until gnt is seen.
  - Deassert req in the gnt cycle; req still high in IDLE after DONE is a new command.
  - A requester that drops req before being sampled is never served.
- Refused increment: gnt is still issued and ctr_inc stays 0. Counter value is unchanged; done with err=1.
- Loads are never refused, including data=MAX_COUNT or 0.
- ctr_ld and ctr_inc are never high together.
- busy = (state != IDLE).
- Reset in ISSUE or DONE aborts the command: no done pulse, and the counter sees no ld/inc after the reset edge. If the counter updated at that same edge, its value stands.
- Reset wins over a simultaneous request.

Test Plan:
- Reset, then req_a=1 op=1 data=5 -> gnt_a the next cycle with ctr_ld=1, ctr_data=5; the cycle after: done=1, done_id=0, err=0, ctr_q=5.
- req_a and req_b both high at the same edge for two commands -> A served first, then B; done_id sequence 0,1; gnt_a and gnt_b never overlap.
- Load 6, then 2x increment from A -> first: ctr_q=7, err=0; second: ctr_inc stays 0, ctr_q=7, done with err=1, reject_cnt=1.
- 256 refused increments at ctr_q=7 -> reject_cnt saturates at 255.
- rst asserted during an ISSUE cycle -> next cycle all outputs 0, no done pulse, priority pointer=A.
- Repeated single requester B, 4 increments from ctr_q=0 -> done every 3 cycles, ctr_q=1,2,3,4, busy low exactly one cycle between commands.

Source files
------------

// File: rtl/counter_sched.sv
// Round-robin arbiter that serialises load/increment commands from two requesters
// onto one shared counter, refusing increments that would wrap past MAX_COUNT.
module counter_sched #(
    parameter int WIDTH     = 3,
    parameter int MAX_COUNT = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_a,
    input  logic             op_a,
    input  logic [WIDTH-1:0] data_a,
    input  logic             req_b,
    input  logic             op_b,
    input  logic [WIDTH-1:0] data_b,
    output logic             gnt_a,
    output logic             gnt_b,
    output logic             done,
    output logic             done_id,
    output logic             err,
    output logic             busy,
    output logic             ctr_ld,
    output logic             ctr_inc,
    output logic [WIDTH-1:0] ctr_data,
    input  logic [WIDTH-1:0] ctr_q,
    output logic [7:0]       reject_cnt
);

    localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MAX_COUNT);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    // Handshake: a requester holds req/op/data until it sees its one-cycle
    // gnt, drops req in the gnt cycle, and gets exactly one done pulse later.
    state_t r_state;
    logic   r_ptr;   // 0 = A has priority on a tie, 1 = B
    logic   r_win;   // requester currently being served
    logic   r_rej;   // current command is a refused increment

    logic             w_req_any;
    logic             w_pick_b;
    logic             w_op;
    logic [WIDTH-1:0] w_data;
    logic             w_at_max;

    assign w_req_any = req_a | req_b;
    assign w_pick_b  = req_b & (~req_a | r_ptr);
    assign w_op      = w_pick_b ? op_b : op_a;
    assign w_data    = w_pick_b ? data_b : data_a;
    assign w_at_max  = (ctr_q == MAX_Q);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_ptr      <= 1'b0;
            r_win      <= 1'b0;
            r_rej      <= 1'b0;
            gnt_a      <= 1'b0;
            gnt_b      <= 1'b0;
            done       <= 1'b0;
            done_id    <= 1'b0;
            err        <= 1'b0;
            busy       <= 1'b0;
            ctr_ld     <= 1'b0;
            ctr_inc    <= 1'b0;
            ctr_data   <= '0;
            reject_cnt <= 8'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_req_any) begin
                        r_state  <= S_ISSUE;
                        r_win    <= w_pick_b;
                        r_rej    <= ~w_op & w_at_max;
                        gnt_a    <= ~w_pick_b;
                        gnt_b    <= w_pick_b;
                        ctr_ld   <= w_op;
                        // Increments are suppressed at MAX_COUNT so the counter never wraps.
                        ctr_inc  <= ~w_op & ~w_at_max;
                        ctr_data <= w_op ? w_data : '0;
                        busy     <= 1'b1;
                    end
                end
                S_ISSUE: begin
                    r_state  <= S_DONE;
                    gnt_a    <= 1'b0;
                    gnt_b    <= 1'b0;
                    ctr_ld   <= 1'b0;
                    ctr_inc  <= 1'b0;
                    ctr_data <= '0;
                    done     <= 1'b1;
                    done_id  <= r_win;
                    err      <= r_rej;
                    r_ptr    <= ~r_win;
                    if (r_rej && reject_cnt != 8'hFF) begin
                        reject_cnt <= reject_cnt + 8'd1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    done    <= 1'b0;
                    done_id <= 1'b0;
                    err     <= 1'b0;
                    busy    <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_counter_sched.sv
// Directed bench for counter_sched: models the shared counter and checks each
// command's grant, completion, counter value and reject count against expectations.
module tb_counter_sched;

    localparam int W   = 3;
    localparam int MAX = 7;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         req_a = 1'b0, op_a = 1'b0, req_b = 1'b0, op_b = 1'b0;
    logic [W-1:0] data_a = '0, data_b = '0;
    logic         gnt_a, gnt_b, done, done_id, err, busy, ctr_ld, ctr_inc;
    logic [W-1:0] ctr_data;
    logic [W-1:0] ctr_q = '0;
    logic [7:0]   reject_cnt;

    int n_checks = 0;
    int n_errors = 0;

    // Expected-result scoreboard entry: {done_id, err, counter value}.
    logic [W+1:0] exp_q[$];
    logic [W-1:0] exp_cnt = '0;
    int           exp_rej_cnt = 0;
    logic         exp_ptr = 1'b0;

    counter_sched #(.WIDTH(W), .MAX_COUNT(MAX)) dut (
        .clk(clk), .rst(rst),
        .req_a(req_a), .op_a(op_a), .data_a(data_a),
        .req_b(req_b), .op_b(op_b), .data_b(data_b),
        .gnt_a(gnt_a), .gnt_b(gnt_b),
        .done(done), .done_id(done_id), .err(err), .busy(busy),
        .ctr_ld(ctr_ld), .ctr_inc(ctr_inc), .ctr_data(ctr_data),
        .ctr_q(ctr_q), .reject_cnt(reject_cnt)
    );

    always #5 clk = ~clk;

    // The shared counter: not reset by the scheduler, wraps naturally.
    always @(posedge clk) begin
        if (ctr_ld) ctr_q <= ctr_data;
        else if (ctr_inc) ctr_q <= ctr_q + 1'b1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic who, input logic op, input logic [W-1:0] data);
        if (who) begin req_b = 1'b1; op_b = op; data_b = data; end
        else     begin req_a = 1'b1; op_a = op; data_a = data; end
    endtask

    // Called at a negedge with who's request already driven and the DUT idle.
    task automatic wait_cmd(input logic who, input logic op, input logic [W-1:0] data);
        logic         rej;
        logic [W-1:0] nxt;
        logic [W+1:0] ent;
        int           n;
        rej = !op && (exp_cnt == W'(MAX));
        nxt = op ? data : (rej ? exp_cnt : exp_cnt + 1'b1);
        exp_q.push_back({who, rej, nxt});
        exp_cnt = nxt;
        if (rej && exp_rej_cnt != 255) exp_rej_cnt++;
        exp_ptr = !who;

        @(negedge clk);
        chk("gnt_a",    8'(gnt_a), 8'(!who));
        chk("gnt_b",    8'(gnt_b), 8'(who));
        chk("ctr_ld",   8'(ctr_ld), 8'(op));
        chk("ctr_inc",  8'(ctr_inc), 8'(!op && !rej));
        chk("ctr_data", 8'(ctr_data), op ? 8'(data) : 8'd0);
        chk("busy_gnt", 8'(busy), 8'd1);
        if (who) req_b = 1'b0; else req_a = 1'b0;

        n = 0;
        @(negedge clk);
        while (!done && n < 4) begin @(negedge clk); n++; end
        chk("done", 8'(done), 8'd1);
        ent = exp_q.pop_front();
        chk("done_id",    8'(done_id), 8'(ent[W+1]));
        chk("err",        8'(err), 8'(ent[W]));
        chk("ctr_q",      8'(ctr_q), 8'(ent[W-1:0]));
        chk("reject_cnt", reject_cnt, 8'(exp_rej_cnt));
        chk("ctrl_idle",  {4'd0, gnt_a, gnt_b, ctr_ld, ctr_inc}, 8'd0);

        @(negedge clk);
        chk("done_low", 8'(done), 8'd0);
        chk("err_low",  8'(err), 8'd0);
        chk("busy_low", 8'(busy), 8'd0);
    endtask

    task automatic run_one(input logic who, input logic op, input logic [W-1:0] data);
        drive(who, op, data);
        wait_cmd(who, op, data);
    endtask

    task automatic run_both(input logic oa, input logic [W-1:0] da,
                            input logic ob, input logic [W-1:0] db);
        logic first;
        drive(1'b0, oa, da);
        drive(1'b1, ob, db);
        first = exp_ptr;
        if (first) begin
            wait_cmd(1'b1, ob, db);
            wait_cmd(1'b0, oa, da);
        end else begin
            wait_cmd(1'b0, oa, da);
            wait_cmd(1'b1, ob, db);
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_outs", {gnt_a, gnt_b, done, done_id, err, busy, ctr_ld, ctr_inc}, 8'd0);
        chk("rst_data", 8'(ctr_data), 8'd0);
        chk("rst_rej",  reject_cnt, 8'd0);
        rst = 1'b0;
        @(negedge clk);

        // Tie after reset: A first, then B.
        run_both(1'b1, 3'd3, 1'b1, 3'd4);
        run_one(1'b0, 1'b1, 3'd5);

        // Load 6, increment to MAX, then a refused increment.
        run_one(1'b0, 1'b1, 3'd6);
        run_one(1'b0, 1'b0, 3'd0);
        run_one(1'b0, 1'b0, 3'd0);

        // Saturate the reject counter.
        for (int i = 0; i < 256; i++) run_one(i[0], 1'b0, 3'($urandom_range(0, 7)));

        // Loads at the range ends are never refused.
        run_one(1'b1, 1'b1, 3'd7);
        run_one(1'b0, 1'b1, 3'd0);
        run_one(1'b1, 1'b1, 3'd7);

        // Abort in ISSUE: A is served so the pointer favours B, then reset.
        run_one(1'b0, 1'b1, 3'd2);
        drive(1'b0, 1'b1, 3'd3);
        @(negedge clk);
        chk("abort_gnt", 8'(gnt_a), 8'd1);
        rst = 1'b1;
        req_a = 1'b0;
        @(negedge clk);
        chk("abort_outs", {gnt_a, gnt_b, done, done_id, err, busy, ctr_ld, ctr_inc}, 8'd0);
        chk("abort_data", 8'(ctr_data), 8'd0);
        chk("abort_rej",  reject_cnt, 8'd0);
        chk("abort_ctr",  8'(ctr_q), 8'd3);
        rst = 1'b0;
        exp_cnt = 3'd3;
        exp_rej_cnt = 0;
        exp_ptr = 1'b0;
        @(negedge clk);
        chk("abort_nodone", 8'(done), 8'd0);
        @(negedge clk);
        chk("abort_nodone2", 8'(done), 8'd0);
        // Pointer is back at A after reset.
        run_both(1'b1, 3'd1, 1'b1, 3'd6);

        // Repeated single requester B counting up from 0.
        run_one(1'b1, 1'b1, 3'd0);
        for (int i = 0; i < 4; i++) run_one(1'b1, 1'b0, 3'd0);

        chk("queue_empty", 8'(exp_q.size()), 8'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
